// File: rtl/minisrc_ctrl_pkg.sv
// Shared Mini SRC control definitions: op codes, branch conditions,
// execute-step state encoding and the per-state strobe decode.
package minisrc_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_BR   = 2'b00,
      OP_JR   = 2'b01,
      OP_JAL  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   // Branch-condition field, shared with the CON FF
   typedef enum logic [1:0] {
      BRZR = 2'b00,
      BRNZ = 2'b01,
      BRPL = 2'b10,
      BRMI = 2'b11
   } brcond_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_BR_T3,
      S_BR_T4,
      S_BR_T5,
      S_BR_T6,
      S_JR_T3,
      S_JAL_T3,
      S_JAL_T4,
      S_DONE
   } state_e;

   typedef struct packed {
      logic gra;
      logic rout;
      logic rin;
      logic r15sel;
      logic conin;
      logic pcout;
      logic pcin;
      logic yin;
      logic cout;
      logic add;
      logic zin;
      logic zlowout;
   } strobe_t;

   // Unconditional strobes of each execute step; the CON-dependent PCin
   // of BR_T6 is added by the controller.
   function automatic strobe_t decode_state(state_e s);
      strobe_t st;
      st = '0;
      case (s)
         S_BR_T3:  begin st.gra = 1'b1; st.rout = 1'b1; st.conin = 1'b1; end
         S_BR_T4:  begin st.pcout = 1'b1; st.yin = 1'b1; end
         S_BR_T5:  begin st.cout = 1'b1; st.add = 1'b1; st.zin = 1'b1; end
         S_BR_T6:  begin st.zlowout = 1'b1; end
         S_JR_T3:  begin st.gra = 1'b1; st.rout = 1'b1; st.pcin = 1'b1; end
         S_JAL_T3: begin st.pcout = 1'b1; st.rin = 1'b1; st.r15sel = 1'b1; end
         S_JAL_T4: begin st.gra = 1'b1; st.rout = 1'b1; st.pcin = 1'b1; end
         default:  ;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/branch_step_controller_if.sv
// Handshake, condition input, datapath strobes and debug counters of the
// branch step controller.
interface branch_step_controller_if #(parameter int CNT_W = 16);
   logic             start;
   logic [1:0]       op;
   logic             run;
   logic             CON;
   logic             busy;
   logic             done;
   logic             illegal;
   logic             Gra, Rout, Rin, R15sel, CONin;
   logic             PCout, PCin, Yin, Cout, ADD, Zin, Zlowout;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] exec_cnt;

   modport master (
      output start, op, run, CON,
      input  busy, done, illegal,
      input  Gra, Rout, Rin, R15sel, CONin,
      input  PCout, PCin, Yin, Cout, ADD, Zin, Zlowout,
      input  taken_cnt, exec_cnt
   );

   modport slave (
      input  start, op, run, CON,
      output busy, done, illegal,
      output Gra, Rout, Rin, R15sel, CONin,
      output PCout, PCin, Yin, Cout, ADD, Zin, Zlowout,
      output taken_cnt, exec_cnt
   );
endinterface

// File: rtl/branch_step_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Next count: step only when requested and not already at the ceiling
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_step_controller.sv
// Execute-step sequencer for Mini SRC branch / jr / jal (T3 onward).
// Strobes are Moore decodes of the state register gated by run.
module branch_step_controller
   import minisrc_ctrl_pkg::*;
#(parameter int CNT_W = 16)
(
   input  logic                    clk,
   input  logic                    reset_n,
   branch_step_controller_if.slave bus
);
   state_e  state_q;
   op_e     op_q;
   logic    illegal_q;
   logic    arm_q;      // low for the first edge after reset release
   strobe_t st;
   logic    taken_inc, exec_inc;

   // Step sequencer; run=0 freezes the state, illegal is a self-clearing pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_BR;
         illegal_q <= 1'b0;
         arm_q     <= 1'b0;
      end else begin
         arm_q     <= 1'b1;
         illegal_q <= 1'b0;
         if (bus.run) begin
            case (state_q)
               S_IDLE: begin
                  if (bus.start && arm_q) begin
                     case (op_e'(bus.op))
                        OP_BR:   begin op_q <= OP_BR;  state_q <= S_BR_T3;  end
                        OP_JR:   begin op_q <= OP_JR;  state_q <= S_JR_T3;  end
                        OP_JAL:  begin op_q <= OP_JAL; state_q <= S_JAL_T3; end
                        default: illegal_q <= 1'b1;
                     endcase
                  end
               end
               S_BR_T3:  state_q <= S_BR_T4;
               S_BR_T4:  state_q <= S_BR_T5;
               S_BR_T5:  state_q <= S_BR_T6;
               S_BR_T6:  state_q <= S_DONE;
               S_JR_T3:  state_q <= S_DONE;
               S_JAL_T3: state_q <= S_JAL_T4;
               S_JAL_T4: state_q <= S_DONE;
               default:  state_q <= S_IDLE;   // S_DONE and any stray code
            endcase
         end
      end
   end

   // Strobe decode; PCin in BR_T6 follows CON directly
   always_comb begin
      st = '0;
      if (bus.run) begin
         st = decode_state(state_q);
         if (state_q == S_BR_T6) st.pcin = bus.CON;
      end
   end

   assign taken_inc = bus.run && (state_q == S_BR_T6) && (op_q == OP_BR) && bus.CON;
   assign exec_inc  = bus.run && (state_q == S_DONE);

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .inc_i (taken_inc),
      .cnt_o (bus.taken_cnt)
   );

   sat_counter #(.W(CNT_W)) u_exec_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .inc_i (exec_inc),
      .cnt_o (bus.exec_cnt)
   );

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);   // held through a stall in DONE
   assign bus.illegal = illegal_q;

   assign bus.Gra     = st.gra;
   assign bus.Rout    = st.rout;
   assign bus.Rin     = st.rin;
   assign bus.R15sel  = st.r15sel;
   assign bus.CONin   = st.conin;
   assign bus.PCout   = st.pcout;
   assign bus.PCin    = st.pcin;
   assign bus.Yin     = st.yin;
   assign bus.Cout    = st.cout;
   assign bus.ADD     = st.add;
   assign bus.Zin     = st.zin;
   assign bus.Zlowout = st.zlowout;
endmodule

// File: tb/tb_branch_step_controller.sv
// Self-checking bench: directed steps then randomized ops against a
// step-table reference model with saturating counter bookkeeping.
module tb_branch_step_controller;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // Strobe bit positions in {Gra,Rout,Rin,R15sel,CONin,PCout,PCin,Yin,Cout,ADD,Zin,Zlowout}
   localparam logic [11:0] GRA = 12'h800, ROUT = 12'h400, RIN = 12'h200, R15 = 12'h100;
   localparam logic [11:0] CONIN = 12'h080, PCOUT = 12'h040, PCIN = 12'h020, YIN = 12'h010;
   localparam logic [11:0] COUT = 12'h008, ADD = 12'h004, ZIN = 12'h002, ZLO = 12'h001;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   branch_step_controller_if #(.CNT_W(CNT_W)) bus();

   branch_step_controller #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int m_taken = 0, m_exec = 0;
   bit m_ill = 1'b0;
   int since = 0;
   int first_done = -1;

   initial begin
      #500000;
      $display("FAIL watchdog expired before end of stimulus");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] strobes();
      return {bus.Gra, bus.Rout, bus.Rin, bus.R15sel, bus.CONin, bus.PCout,
              bus.PCin, bus.Yin, bus.Cout, bus.ADD, bus.Zin, bus.Zlowout};
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // Reference step table: strobes required in execute step i of an op
   function automatic logic [11:0] step_of(input logic [1:0] op, input int i, input logic con);
      case (op)
         2'b00: case (i)
                   0: return GRA | ROUT | CONIN;
                   1: return PCOUT | YIN;
                   2: return COUT | ADD | ZIN;
                   default: return ZLO | (con ? PCIN : 12'h000);
                endcase
         2'b01: return GRA | ROUT | PCIN;
         default: return (i == 0) ? (PCOUT | RIN | R15) : (GRA | ROUT | PCIN);
      endcase
   endfunction

   function automatic int nsteps_of(input logic [1:0] op);
      case (op)
         2'b00: return 4;
         2'b01: return 1;
         2'b10: return 2;
         default: return 0;
      endcase
   endfunction

   // Check outputs mid-cycle, after inputs have settled
   task automatic cyc_chk(input logic [11:0] es, input logic eb, input logic ed);
      @(negedge clk);
      chk("strobes", strobes(), es);
      chk("busy", bus.busy, eb);
      chk("done", bus.done, ed);
      chk("illegal", bus.illegal, m_ill);
      chk("taken_cnt", bus.taken_cnt, m_taken);
      chk("exec_cnt", bus.exec_cnt, m_exec);
      m_ill = 1'b0;
      if (bus.done && first_done < 0) first_done = since;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      since++;
   endtask

   task automatic drive(input logic r, input int con_mode, input bit noise);
      bus.run   = r;
      bus.CON   = (con_mode == 2) ? 1'($urandom) : con_mode[0];
      bus.start = noise ? 1'($urandom) : 1'b0;
      bus.op    = noise ? 2'($urandom) : 2'b00;
   endtask

   task automatic idle();
      bus.start = 1'b0;
      bus.run   = 1'b1;
      cyc_chk(12'h000, 1'b0, 1'b0);
      adv();
   endtask

   // One instruction: accept cycle, execute steps (optional stall before
   // step stall_step), DONE (optional stall), with latency check.
   task automatic do_op(input logic [1:0] op, input int con_mode, input int stall_step,
                        input int stall_len, input int done_stall, input bit noise);
      int n;
      int lat;
      logic c;
      n = nsteps_of(op);
      bus.start = 1'b1;
      bus.op    = op;
      bus.run   = 1'b1;
      bus.CON   = 1'($urandom);
      cyc_chk(12'h000, 1'b0, 1'b0);
      since = 0;
      first_done = -1;
      adv();
      if (op == 2'b11) begin
         bus.start = 1'b0;
         m_ill = 1'b1;
         return;
      end
      lat = n + 1;
      for (int i = 0; i < n; i++) begin
         if (i == stall_step) begin
            lat += stall_len;
            for (int k = 0; k < stall_len; k++) begin
               drive(1'b0, con_mode, noise);
               cyc_chk(12'h000, 1'b1, 1'b0);
               adv();
            end
         end
         drive(1'b1, con_mode, noise);
         c = bus.CON;
         cyc_chk(step_of(op, i, c), 1'b1, 1'b0);
         adv();
         if (op == 2'b00 && i == 3 && c) m_taken = sat(m_taken + 1);
      end
      for (int k = 0; k < done_stall; k++) begin
         drive(1'b0, con_mode, noise);
         cyc_chk(12'h000, 1'b1, 1'b1);
         adv();
      end
      drive(1'b1, con_mode, noise);
      cyc_chk(12'h000, 1'b1, 1'b1);
      adv();
      m_exec = sat(m_exec + 1);
      chk("latency", first_done, lat);
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.run   = 1'b1;
      bus.CON   = 1'b0;

      // Reset state
      #2;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_illegal", bus.illegal, 1'b0);
      chk("rst_strobes", strobes(), 12'h000);
      chk("rst_taken", bus.taken_cnt, 0);
      chk("rst_exec", bus.exec_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      idle();

      // BR taken, BR not taken
      do_op(2'b00, 1, 9, 0, 0, 1'b0);
      chk("br1_taken", bus.taken_cnt, 1);
      chk("br1_exec", bus.exec_cnt, 1);
      do_op(2'b00, 0, 9, 0, 0, 1'b0);
      chk("br0_taken", bus.taken_cnt, 1);
      chk("br0_exec", bus.exec_cnt, 2);

      // JR then JAL back to back
      do_op(2'b01, 2, 9, 0, 0, 1'b0);
      chk("jr_lat", first_done, 2);
      do_op(2'b10, 2, 9, 0, 0, 1'b0);
      chk("jal_lat", first_done, 3);

      // Three-cycle stall in BR_T5
      do_op(2'b00, 1, 2, 3, 0, 1'b0);
      chk("stall_lat", first_done, 8);
      idle();

      // Async reset in BR_T4
      bus.start = 1'b1;
      bus.op    = 2'b00;
      cyc_chk(12'h000, 1'b0, 1'b0);
      adv();
      bus.start = 1'b0;
      cyc_chk(GRA | ROUT | CONIN, 1'b1, 1'b0);
      adv();
      #2;
      reset_n = 1'b0;
      #1;
      m_taken = 0;
      m_exec  = 0;
      m_ill   = 1'b0;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_strobes", strobes(), 12'h000);
      chk("arst_done", bus.done, 1'b0);
      chk("arst_taken", bus.taken_cnt, 0);
      chk("arst_exec", bus.exec_cnt, 0);
      @(posedge clk);
      @(negedge clk);
      reset_n   = 1'b1;
      bus.start = 1'b1;
      bus.op    = 2'b01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc_chk(12'h000, 1'b0, 1'b0);   // start at release edge ignored
      adv();
      do_op(2'b01, 2, 9, 0, 0, 1'b0);

      // Reserved op
      do_op(2'b11, 2, 9, 0, 0, 1'b0);
      idle();
      idle();

      // Saturation of taken_cnt at 3
      for (int i = 0; i < 4; i++) do_op(2'b00, 1, 9, 0, 0, 1'b0);
      chk("taken_sat", bus.taken_cnt, 3);
      chk("exec_sat", bus.exec_cnt, 3);

      // Randomized ops with stalls, DONE stalls and start noise while busy
      for (int r = 0; r < 80; r++) begin
         do_op(2'($urandom), 2, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 2)), 1'b1);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_step_controller.md
Name: branch_step_controller

Overview:
- Control-step FSM that sequences the conditional flip-flop (CON FF) and the PC/Y/Z datapath through the execute steps of Mini SRC control-transfer instructions: branch (brzr/brnz/brpl/brmi), jr and jal.
- Sits beside the main control unit. The main unit performs fetch/decode (T0–T2), then hands off via a start/done handshake. This block drives the datapath strobes for T3 onward.
- Keeps a saturating count of branches taken, for debug.

Parameters:
- CNT_W, 16, width of the taken-branch and executed-branch counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  main control unit requests execution; sampled only in IDLE.
- op  in  2  00=BR, 01=JR, 10=JAL, 11=reserved; captured with start.
- run  in  1  step enable; low freezes state and deasserts all strobes.
- CON  in  1  output of the CON FF.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on completion.
- illegal  out  1  one-cycle pulse when start arrives with op=11.
- Gra, Rout, Rin, R15sel  out  1 each  register-file select, out and in strobes (R15sel forces the destination to R15).
- CONin  out  1  CON FF load enable.
- PCout, PCin, Yin, Cout, ADD, Zin, Zlowout  out  1 each  datapath strobes.
- taken_cnt  out  CNT_W  saturating count of BR instructions with CON=1 at T6.
- exec_cnt  out  CNT_W  saturating count of all completed ops.

Behaviour:
- States: IDLE, BR_T3, BR_T4, BR_T5, BR_T6, JR_T3, JAL_T3, JAL_T4, DONE.
- Strobes are Moore decodes of the registered state, ANDed with run. All strobes are 0 in IDLE and DONE.
- IDLE:
  - start=1 with op=00 goes to BR_T3; op=01 goes to JR_T3; op=10 goes to JAL_T3.
  - start=1 with op=11 stays in IDLE and pulses illegal for 1 cycle.
  - op is latched into an internal register on acceptance. start while busy is ignored.
- BR_T3: Gra, Rout, CONin. CON becomes valid on the following edge.
- BR_T4: PCout, Yin.
- BR_T5: Cout, ADD, Zin.
- BR_T6: Zlowout; PCin only if CON=1. CON is sampled combinationally in this state.
- JR_T3: Gra, Rout, PCin.
- JAL_T3: PCout, Rin, R15sel (R15 ← PC).
- JAL_T4: Gra, Rout, PCin.
- Last execute state → DONE. DONE asserts done for exactly 1 cycle, then goes to IDLE. busy falls in the same cycle as the move to IDLE.
- Latency, counted from the start-accept edge to the done cycle with run held high: BR 5 cycles, JR 2, JAL 3.
- run=0:
  - State holds and all strobes read 0.
  - Counters do not update.
  - done is held high for as long as the stall lasts in DONE.
  - Sequencing resumes exactly where it stopped when run returns to 1.
- Counters:
  - Each step in this list happens on the edge that leaves the named state, and only when run=1.
  - exec_cnt increments on leaving DONE.
  - taken_cnt increments on leaving BR_T6 if CON=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- Reset: async assertion anywhere, including mid-sequence, forces IDLE immediately. All strobes, busy, done, illegal = 0; counters = 0; latched op = 00. Release is synchronous to the next edge.
- A start in the same cycle as reset release is ignored.
- The reserved op never leaves IDLE.

Decomposition:
- Shared package `minisrc_ctrl_pkg`: op encodings (OP_BR, OP_JR, OP_JAL, OP_RSVD), state enumeration, branch-condition encodings (BRZR=00, BRNZ=01, BRPL=10, BRMI=11) shared with the CON FF.
- Sub-module `sat_counter` (parameter W; inc; async active-low reset), instantiated twice for taken_cnt and exec_cnt.

Test Plan:
- Reset, then start with op=00 and CON forced to 1, run=1:
  - strobes follow {Gra,Rout,CONin} → {PCout,Yin} → {Cout,ADD,Zin} → {Zlowout,PCin}.
  - done appears at cycle 5; taken_cnt=1, exec_cnt=1.
- BR with CON=0: BR_T6 asserts Zlowout with PCin=0; taken_cnt stays unchanged; exec_cnt increments.
- JR then JAL back to back, with start re-asserted the cycle after each done:
  - JR: done 2 cycles after accept.
  - JAL: Rin+R15sel+PCout in T3, then Gra+Rout+PCin in T4; done 3 cycles after accept.
- run low for 3 cycles during BR_T5:
  - all strobes 0 during the stall; state is held.
  - on resume, Cout/ADD/Zin appear for 1 cycle; total latency is 8 cycles.
- reset_n pulsed low in BR_T4:
  - busy and all strobes go 0 without waiting for clk; counters read 0.
  - the next start with op=01 executes JR normally.
- start with op=11: illegal pulses 1 cycle, busy stays 0. Also force taken_cnt to near-max with CNT_W=2: it saturates at 3 after 4 taken branches.
